dkong_rom_loader: RTL and testbench

Upstream stage between `hps_io` and the Donkey Kong core's ROM/RAM arrays. Decodes the HPS ioctl download stream into registered per-region write strobes (main CPU ROM, core DL port, sound CPU ROM, wave ROM), latches the game-variant mod byte and DIP bank, and keeps a running checksum. Holds a core reset from download start until a fixed number of cycles after download end.

---
 rtl/dkong_rom_loader_if.sv | 17 +
 rtl/dkong_rom_loader.sv | 164 ++++++++++++++++
 tb/tb_dkong_rom_loader.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dkong_rom_loader_if.sv
// HPS ioctl download bus as seen by the Donkey Kong ROM loader.
// The HPS side drives everything; the loader only listens.
interface dkong_rom_loader_if;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;

  modport master (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout
  );

  modport slave (
    input ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout
  );
endinterface

// File: rtl/dkong_rom_loader.sv
// Splits the HPS ROM download into per-region write strobes, latches mod/DIP bytes,
// keeps a checksum and holds the core in reset around each ROM download.
module dkong_rom_loader #(
  parameter int HOLD_CYCLES = 1024
) (
  input  logic                     clk_sys,
  input  logic                     reset,
  dkong_rom_loader_if.slave        ioctl,
  output logic [15:0]              wr_addr,
  output logic [7:0]               wr_data,
  output logic                     cpu_we,
  output logic                     dl_we,
  output logic                     snd_we,
  output logic                     wav_we,
  output logic [7:0]               mod,
  output logic [7:0]               dip_sw0,
  output logic                     core_reset,
  output logic                     load_done,
  output logic                     bad_addr,
  output logic [7:0]               checksum
);

  localparam int NREG = 4;
  localparam logic [15:0] HOLD_LOAD = 16'(HOLD_CYCLES - 1);

  // Region order matches the strobe vector: cpu, dl, snd, wav.
  localparam logic [24:0] REGION_LO   [NREG] = '{25'h00000, 25'h08000, 25'h0E000, 25'h10000};
  localparam logic [24:0] REGION_SIZE [NREG] = '{25'h08000, 25'h06000, 25'h01000, 25'h10000};
  localparam logic [15:0] REGION_MASK [NREG] = '{16'h7FFF, 16'hFFFF, 16'h0FFF, 16'hFFFF};

  typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;

  state_t          state_reg;
  logic [15:0]     hold_cnt_reg;
  logic            core_reset_reg;
  logic            load_done_reg;
  logic [NREG-1:0] we_reg;
  logic [15:0]     wr_addr_reg;
  logic [7:0]      wr_data_reg;
  logic [7:0]      mod_reg;
  logic [7:0]      dip_sw0_reg;
  logic [7:0]      checksum_reg;
  logic            bad_addr_reg;

  logic            rom_byte;
  logic            rom_start;
  logic            entering_load;
  logic [NREG-1:0] hit;
  logic [15:0]     region_addr [NREG];
  logic [15:0]     wr_addr_next;
  logic            any_hit;
  logic            miss;
  logic [7:0]      checksum_base;
  logic [7:0]      checksum_next;
  logic            bad_addr_next;

  assign rom_byte      = ioctl.ioctl_download && ioctl.ioctl_wr && (ioctl.ioctl_index == 8'd0);
  assign rom_start     = ioctl.ioctl_download && (ioctl.ioctl_index == 8'd0);
  assign entering_load = rom_start && (state_reg != LOAD);

  // Offset compare wraps below the base, so one unsigned test covers both bounds.
  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_region
      assign hit[gi] = rom_byte &&
                       ((ioctl.ioctl_addr - REGION_LO[gi]) < REGION_SIZE[gi]);
      assign region_addr[gi] = hit[gi] ? (ioctl.ioctl_addr[15:0] & REGION_MASK[gi]) : 16'h0000;
    end
  endgenerate

  always_comb begin
    wr_addr_next = 16'h0000;
    for (int i = 0; i < NREG; i++) begin
      wr_addr_next = wr_addr_next | region_addr[i];
    end
  end

  assign any_hit = |hit;
  assign miss    = rom_byte && !any_hit;

  // A new ROM download starts the checksum and error flag afresh, yet still
  // counts a byte that arrives on the very first download cycle.
  assign checksum_base = entering_load ? 8'h00 : checksum_reg;
  assign checksum_next = checksum_base + (any_hit ? ioctl.ioctl_dout : 8'h00);
  assign bad_addr_next = (entering_load ? 1'b0 : bad_addr_reg) | miss;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_reg      <= HOLD;
      hold_cnt_reg   <= HOLD_LOAD;
      core_reset_reg <= 1'b1;
      load_done_reg  <= 1'b0;
      we_reg         <= '0;
      wr_addr_reg    <= 16'h0000;
      wr_data_reg    <= 8'h00;
      mod_reg        <= 8'h00;
      dip_sw0_reg    <= 8'h00;
      checksum_reg   <= 8'h00;
      bad_addr_reg   <= 1'b0;
    end else begin
      load_done_reg <= 1'b0;
      we_reg        <= hit;
      checksum_reg  <= checksum_next;
      bad_addr_reg  <= bad_addr_next;

      if (any_hit) begin
        wr_addr_reg <= wr_addr_next;
        wr_data_reg <= ioctl.ioctl_dout;
      end

      if (ioctl.ioctl_wr && ioctl.ioctl_index == 8'd1) begin
        mod_reg <= ioctl.ioctl_dout;
      end

      // Only DIP byte 0 is kept; the rest of the 8-byte bank is discarded.
      if (ioctl.ioctl_wr && ioctl.ioctl_index == 8'd254 && ioctl.ioctl_addr == 25'd0) begin
        dip_sw0_reg <= ioctl.ioctl_dout;
      end

      case (state_reg)
        IDLE: begin
          if (rom_start) begin
            state_reg      <= LOAD;
            core_reset_reg <= 1'b1;
          end
        end
        LOAD: begin
          if (!ioctl.ioctl_download) begin
            state_reg    <= HOLD;
            hold_cnt_reg <= HOLD_LOAD;
          end
        end
        HOLD: begin
          if (rom_start) begin
            state_reg <= LOAD;
          end else if (hold_cnt_reg == 16'd0) begin
            state_reg      <= IDLE;
            load_done_reg  <= 1'b1;
            core_reset_reg <= 1'b0;
          end else begin
            hold_cnt_reg <= hold_cnt_reg - 16'd1;
          end
        end
        default: begin
          state_reg <= HOLD;
        end
      endcase
    end
  end

  assign cpu_we     = we_reg[0];
  assign dl_we      = we_reg[1];
  assign snd_we     = we_reg[2];
  assign wav_we     = we_reg[3];
  assign wr_addr    = wr_addr_reg;
  assign wr_data    = wr_data_reg;
  assign mod        = mod_reg;
  assign dip_sw0    = dip_sw0_reg;
  assign core_reset = core_reset_reg;
  assign load_done  = load_done_reg;
  assign bad_addr   = bad_addr_reg;
  assign checksum   = checksum_reg;

endmodule

// File: tb/tb_dkong_rom_loader.sv
// Directed plus randomized bench for dkong_rom_loader against an address-map reference model.
module tb_dkong_rom_loader;
  localparam int H = 1024;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        cpu_we, dl_we, snd_we, wav_we;
  logic [7:0]  mod, dip_sw0, checksum;
  logic        core_reset, load_done, bad_addr;
  logic [3:0]  we_vec;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_sum = 8'h00;
  logic [7:0] exp_mod = 8'h00;
  logic [7:0] exp_dip = 8'h00;
  logic       exp_bad = 1'b0;

  always #5 clk_sys = ~clk_sys;

  dkong_rom_loader_if ioctl ();

  dkong_rom_loader #(.HOLD_CYCLES(H)) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .ioctl      (ioctl),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .cpu_we     (cpu_we),
    .dl_we      (dl_we),
    .snd_we     (snd_we),
    .wav_we     (wav_we),
    .mod        (mod),
    .dip_sw0    (dip_sw0),
    .core_reset (core_reset),
    .load_done  (load_done),
    .bad_addr   (bad_addr),
    .checksum   (checksum)
  );

  assign we_vec = {wav_we, snd_we, dl_we, cpu_we};

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Reference address map: -1 means outside every region.
  function automatic int region_of(input logic [24:0] a);
    if (a < 25'h08000)      return 0;
    else if (a < 25'h0E000) return 1;
    else if (a < 25'h0F000) return 2;
    else if (a >= 25'h10000 && a < 25'h20000) return 3;
    else return -1;
  endfunction

  function automatic logic [15:0] rel_addr(input int r, input logic [24:0] a);
    case (r)
      0:       return 16'(a % 25'h08000);
      2:       return 16'(a % 25'h01000);
      default: return 16'(a % 25'h10000);
    endcase
  endfunction

  task automatic put_byte(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d);
    int r;
    logic [3:0] exp_we;
    exp_we = 4'b0000;
    r = (idx == 8'd0 && ioctl.ioctl_download) ? region_of(a) : -2;
    if (r >= 0) begin
      exp_we  = 4'(1 << r);
      exp_sum = exp_sum + d;
    end else if (r == -1) begin
      exp_bad = 1'b1;
    end
    if (idx == 8'd1) exp_mod = d;
    if (idx == 8'd254 && a == 25'd0) exp_dip = d;
    ioctl.ioctl_index = idx;
    ioctl.ioctl_addr  = a;
    ioctl.ioctl_dout  = d;
    ioctl.ioctl_wr    = 1'b1;
    step();
    $display("byte idx=%0d addr=0x%05h data=0x%02h we=%b wr_addr=0x%04h sum=0x%02h bad=%0d",
             idx, a, d, we_vec, wr_addr, checksum, bad_addr);
    check("we", 32'(we_vec), 32'(exp_we));
    if (r >= 0) begin
      check("wr_addr", 32'(wr_addr), 32'(rel_addr(r, a)));
      check("wr_data", 32'(wr_data), 32'(d));
    end
    check("checksum", 32'(checksum), 32'(exp_sum));
    check("bad_addr", 32'(bad_addr), 32'(exp_bad));
    check("mod", 32'(mod), 32'(exp_mod));
    check("dip_sw0", 32'(dip_sw0), 32'(exp_dip));
  endtask

  task automatic idle_cycle();
    ioctl.ioctl_wr = 1'b0;
    step();
    check("we_idle", 32'(we_vec), 32'd0);
  endtask

  // Called right after the edge that starts the hold (reset or download drop).
  task automatic wait_done(input string tag);
    int k;
    int cr_low;
    k = 0;
    cr_low = 0;
    while (k < 3 * H) begin
      step();
      k++;
      if (load_done) break;
      if (!core_reset) cr_low++;
    end
    $display("hold %s: load_done after %0d cycles", tag, k);
    check({tag, "_latency"}, 32'(k), 32'(H));
    check({tag, "_reset_held"}, 32'(cr_low), 32'd0);
    check({tag, "_core_reset_off"}, 32'(core_reset), 32'd0);
    step();
    check({tag, "_pulse_width"}, 32'(load_done), 32'd0);
  endtask

  initial begin
    int early_done;
    int cr_low;
    logic [24:0] ra;

    ioctl.ioctl_download = 1'b0;
    ioctl.ioctl_index    = 8'd0;
    ioctl.ioctl_wr       = 1'b0;
    ioctl.ioctl_addr     = 25'd0;
    ioctl.ioctl_dout     = 8'd0;
    reset = 1'b1;
    step();
    check("rst_we", 32'(we_vec), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_mod", 32'(mod), 32'd0);
    check("rst_dip", 32'(dip_sw0), 32'd0);
    check("rst_checksum", 32'(checksum), 32'd0);
    check("rst_bad", 32'(bad_addr), 32'd0);
    check("rst_core_reset", 32'(core_reset), 32'd1);
    check("rst_load_done", 32'(load_done), 32'd0);
    reset = 1'b0;
    wait_done("powerup");
    check("powerup_checksum", 32'(checksum), 32'd0);
    check("powerup_mod", 32'(mod), 32'd0);

    // Non-ROM downloads never touch core_reset.
    ioctl.ioctl_download = 1'b1;
    put_byte(8'd1, 25'd0, 8'h02);
    put_byte(8'd1, 25'd1, 8'h04);
    ioctl.ioctl_download = 1'b0;
    idle_cycle();
    check("mod_last", 32'(mod), 32'h04);
    check("mod_core_reset", 32'(core_reset), 32'd0);
    put_byte(8'd254, 25'd0, 8'h5A);
    put_byte(8'd254, 25'd8, 8'h33);
    idle_cycle();
    check("dip_value", 32'(dip_sw0), 32'h5A);
    check("dip_core_reset", 32'(core_reset), 32'd0);
    check("dip_load_done", 32'(load_done), 32'd0);

    // ROM download.
    ioctl.ioctl_index    = 8'd0;
    ioctl.ioctl_download = 1'b1;
    exp_sum = 8'h00;
    exp_bad = 1'b0;
    step();
    check("start_core_reset", 32'(core_reset), 32'd1);
    put_byte(8'd0, 25'h00123, 8'hA5);
    put_byte(8'd0, 25'h0E010, 8'h3C);
    put_byte(8'd0, 25'h1FFFF, 8'h11);
    check("sum_three", 32'(checksum), 32'hF2);
    idle_cycle();
    put_byte(8'd0, 25'h0F800, 8'h7F);
    check("bad_set", 32'(bad_addr), 32'd1);
    check("bad_sum_kept", 32'(checksum), 32'hF2);
    put_byte(8'd0, 25'h07FFF, 8'h01);
    put_byte(8'd0, 25'h08000, 8'h02);
    put_byte(8'd0, 25'h0DFFF, 8'h03);
    put_byte(8'd0, 25'h0E000, 8'h04);
    put_byte(8'd0, 25'h0EFFF, 8'h05);
    put_byte(8'd0, 25'h0FFFF, 8'h06);
    put_byte(8'd0, 25'h10000, 8'h07);
    put_byte(8'd0, 25'h20000, 8'h08);
    for (int i = 0; i < 60; i++) begin
      ra = 25'($urandom_range(0, 32'h2FFFF));
      put_byte(8'd0, ra, 8'($urandom));
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end

    // Strobe coincident with the download drop is dropped.
    ioctl.ioctl_addr     = 25'h00100;
    ioctl.ioctl_dout     = 8'h55;
    ioctl.ioctl_wr       = 1'b1;
    ioctl.ioctl_download = 1'b0;
    step();
    check("drop_we", 32'(we_vec), 32'd0);
    check("drop_checksum", 32'(checksum), 32'(exp_sum));
    ioctl.ioctl_wr = 1'b0;

    // Restart the download while the hold counter sits at 500.
    early_done = 0;
    cr_low = 0;
    for (int i = 0; i < 523; i++) begin
      step();
      if (load_done) early_done++;
      if (!core_reset) cr_low++;
    end
    check("hold_no_done", 32'(early_done), 32'd0);
    check("hold_core_reset", 32'(cr_low), 32'd0);
    ioctl.ioctl_download = 1'b1;
    exp_sum = 8'h00;
    exp_bad = 1'b0;
    step();
    check("restart_checksum", 32'(checksum), 32'd0);
    check("restart_bad", 32'(bad_addr), 32'd0);
    check("restart_core_reset", 32'(core_reset), 32'd1);
    put_byte(8'd0, 25'h00042, 8'h9C);
    ioctl.ioctl_wr = 1'b0;
    early_done = 0;
    for (int i = 0; i < 600; i++) begin
      step();
      if (load_done) early_done++;
    end
    check("restart_no_done", 32'(early_done), 32'd0);
    ioctl.ioctl_download = 1'b0;
    step();
    wait_done("reload");
    check("reload_checksum", 32'(checksum), 32'h9C);

    // Reset in the middle of a ROM download.
    ioctl.ioctl_download = 1'b1;
    step();
    check("load2_core_reset", 32'(core_reset), 32'd1);
    ioctl.ioctl_addr = 25'h00200;
    ioctl.ioctl_dout = 8'h99;
    ioctl.ioctl_wr   = 1'b1;
    reset = 1'b1;
    step();
    check("midrst_we", 32'(we_vec), 32'd0);
    check("midrst_core_reset", 32'(core_reset), 32'd1);
    check("midrst_checksum", 32'(checksum), 32'd0);
    check("midrst_mod", 32'(mod), 32'd0);
    reset = 1'b0;
    ioctl.ioctl_wr = 1'b0;
    ioctl.ioctl_download = 1'b0;
    wait_done("midload_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
